// File: rtl/collatz_sweep.sv
// rtl/collatz_sweep.sv - sweeps consecutive start values, stores Collatz lengths in RAM
// Optional longest-sequence tracking is built when COLLATZ_MAX_TRACK_EN is defined.
module collatz_sweep #(
    parameter int N_BITS        = 32,
    parameter int COUNT_BITS    = 16,
    parameter int RAM_WORDS     = 16,
    parameter int RAM_ADDR_BITS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    input  logic [N_BITS-1:0]        start,
    input  logic [RAM_ADDR_BITS-1:0] rd_addr,
    output logic [COUNT_BITS-1:0]    rd_data,
    output logic                     busy,
    output logic                     done,
    output logic                     ovf,
    output logic [COUNT_BITS-1:0]    max_count,
    output logic [N_BITS-1:0]        max_start
);

    localparam int DEPTH = 1 << RAM_ADDR_BITS;
    localparam int W3    = N_BITS + 2;
    localparam logic [RAM_ADDR_BITS-1:0] LAST_IDX = RAM_ADDR_BITS'(RAM_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic [N_BITS-1:0]        cur_q, cur_d;
    logic [N_BITS-1:0]        n_q, n_d;
    logic [COUNT_BITS-1:0]    cnt_q, cnt_d;
    logic [RAM_ADDR_BITS-1:0] idx_q, idx_d;
    logic                     ovf_q, ovf_d;
    logic [COUNT_BITS-1:0]    rd_data_q;
    logic                     wr_en;
    logic [W3-1:0]            n3;
    logic                     n3_ovf;

    logic [COUNT_BITS-1:0]    mem [DEPTH];

    // 3n+1 in two extra bits so an out-of-range result is visible
    assign n3     = {2'b00, n_q} + {1'b0, n_q, 1'b0} + W3'(1);
    assign n3_ovf = |n3[W3-1:N_BITS];

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (go) begin
                    cur_d   = start;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                n_d     = cur_q;
                cnt_d   = COUNT_BITS'(1);
                state_d = S_ITER;
            end
            S_ITER: begin
                if (n_q == '0) begin
                    cnt_d   = '0;
                    state_d = S_WRITE;
                end else if (n_q == N_BITS'(1)) begin
                    state_d = S_WRITE;
                end else if (cnt_q == '1) begin
                    ovf_d   = 1'b1;
                    state_d = S_WRITE;
                end else if (n_q[0] && n3_ovf) begin
                    cnt_d   = '1;
                    ovf_d   = 1'b1;
                    state_d = S_WRITE;
                end else begin
                    n_d   = n_q[0] ? n3[N_BITS-1:0] : (n_q >> 1);
                    cnt_d = cnt_q + COUNT_BITS'(1);
                end
            end
            S_WRITE: begin
                wr_en = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + RAM_ADDR_BITS'(1);
                    cur_d   = cur_q + N_BITS'(1);
                    state_d = S_LOAD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            n_q       <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            ovf_q     <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            n_q       <= n_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            ovf_q     <= ovf_d;
            rd_data_q <= mem[rd_addr];
        end
    end

    // RAM is never cleared; a write in a reset cycle is suppressed
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[idx_q] <= cnt_q;
        end
    end

`ifdef COLLATZ_MAX_TRACK_EN
    logic [COUNT_BITS-1:0] max_count_q, max_count_d;
    logic [N_BITS-1:0]     max_start_q, max_start_d;
    logic                  clear_max;

    assign clear_max = ((state_q == S_IDLE) || (state_q == S_DONE)) && go;

    // strict compare keeps the earliest start on ties
    always_comb begin
        max_count_d = max_count_q;
        max_start_d = max_start_q;
        if (clear_max) begin
            max_count_d = '0;
            max_start_d = '0;
        end else if (wr_en && (cnt_q > max_count_q)) begin
            max_count_d = cnt_q;
            max_start_d = cur_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            max_count_q <= '0;
            max_start_q <= '0;
        end else begin
            max_count_q <= max_count_d;
            max_start_q <= max_start_d;
        end
    end

    assign max_count = max_count_q;
    assign max_start = max_start_q;
`else
    assign max_count = '0;
    assign max_start = '0;
`endif

    assign rd_data = rd_data_q;
    assign busy    = (state_q == S_LOAD) || (state_q == S_ITER) || (state_q == S_WRITE);
    assign done    = (state_q == S_DONE);
    assign ovf     = ovf_q;

endmodule
